// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared FSM state type and BCD nibble width for bin2bcd_seq
package bin2bcd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction, adds 3 to any digit >= 5
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digitIn,
    output logic [NIBBLE_W-1:0] digitOut
);

    // Digits 5..9 become 8..12; the carry into the next digit comes from the shift.
    assign digitOut = (digitIn >= NIBBLE_W'(5)) ? digitIn + NIBBLE_W'(3) : digitIn;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter with leading-zero blanking
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iSTART,
    input  logic [WIDTH-1:0]           iBIN,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic [NIBBLE_W*DIGITS-1:0] oBCD,
    output logic [DIGITS-1:0]          oBLANK
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = NIBBLE_W * DIGITS;

    if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : gBadDigits
        $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
    end

    stateT             state;
    logic [WIDTH-1:0]  shiftReg;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  adjusted;
    logic [BCD_W-1:0]  nextScratch;
    logic [CNT_W-1:0]  bitCnt;

    // Digit 0 is never blanked so a zero result still shows one "0".
    function automatic logic [DIGITS-1:0] calcBlank(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] blank;
        logic              allZero;
        blank   = '0;
        allZero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            allZero  = allZero && (bcd[k*NIBBLE_W +: NIBBLE_W] == '0);
            blank[k] = allZero;
        end
        return blank;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : gAdj
        bcd_digit_adj uAdj (
            .digitIn (scratch[g*NIBBLE_W +: NIBBLE_W]),
            .digitOut(adjusted[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    assign nextScratch = {adjusted[BCD_W-2:0], shiftReg[WIDTH-1]};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            shiftReg <= '0;
            scratch  <= '0;
            bitCnt   <= '0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
            oBCD     <= '0;
            oBLANK   <= calcBlank('0);
        end else begin
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        shiftReg <= iBIN;
                        scratch  <= '0;
                        bitCnt   <= CNT_W'(WIDTH);
                        oBUSY    <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch  <= nextScratch;
                    shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
                    bitCnt   <= bitCnt - CNT_W'(1);
                    // Outputs are registered, so the final result is loaded on the edge entering DONE.
                    if (bitCnt == CNT_W'(1)) begin
                        state  <= DONE;
                        oDONE  <= 1'b1;
                        oBCD   <= nextScratch;
                        oBLANK <= calcBlank(nextScratch);
                    end
                end
                DONE: begin
                    oDONE <= 1'b0;
                    oBUSY <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16, binary input width in bits.
REQ-002 Parameter DIGITS, default 5, number of BCD output digits; the block SHALL require 10**DIGITS > 2**WIDTH-1, checked at elaboration.
REQ-003 iCLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 iRST  input  1  reset, asynchronous and active-high.
REQ-005 iSTART  input  1  conversion request; sampled only when oBUSY=0.
REQ-006 iBIN  input  WIDTH  unsigned binary value; sampled on the same edge as an accepted iSTART.
REQ-007 oBUSY  output  1  high while a conversion is in progress.
REQ-008 oDONE  output  1  single-cycle pulse: oBCD/oBLANK have just been updated.
REQ-009 oBCD  output  4*DIGITS  packed BCD result; digit k on bits [4k+3:4k], digit 0 least significant; each nibble drives one 7-segment decoder input.
REQ-010 oBLANK  output  DIGITS  leading-zero blanking mask, bit k = digit k is a leading zero.

Function
REQ-011 FSM states IDLE, SHIFT, DONE: IDLE->SHIFT on iSTART; SHIFT->DONE after exactly WIDTH shift cycles; DONE->IDLE unconditionally.
REQ-012 On accepting iSTART: latch iBIN into the shift register, clear the BCD scratch register, load the bit counter with WIDTH.
REQ-013 Each SHIFT cycle: every scratch digit >= 5 gets +3 (4-bit result, no carry between digits), then {scratch, shift} shifts left one bit, MSB of iBIN first.
REQ-014 In DONE: copy scratch to oBCD, compute oBLANK, assert oDONE for exactly this one cycle.
REQ-015 Latency: oDONE high in the (WIDTH+1)th cycle after the edge that accepts iSTART (17 cycles for WIDTH=16).
REQ-016 oBUSY=1 in SHIFT and DONE, 0 in IDLE; iSTART and iBIN ignored while oBUSY=1 (no queuing).
REQ-017 oBCD and oBLANK change only in DONE; between conversions they hold the last result.
REQ-018 oBLANK bit k (k>=1) =1 iff digit k and every more-significant digit are zero; bit 0 always 0, so value 0 displays a single "0".
REQ-019 Back-to-back: iSTART high in the cycle after oDONE (state IDLE) is accepted immediately.
REQ-020 Every digit in oBCD SHALL be in 0..9; no nibble value 10..15 is ever produced.

Reset
REQ-021 iRST high SHALL force, asynchronously: state IDLE, oBUSY=0, oDONE=0, oBCD=0, oBLANK={1 in bits DIGITS-1..1, 0 in bit 0}, counter and scratch cleared.
REQ-022 Reset asserted mid-conversion SHALL abort it: no oDONE pulse, no partial oBCD update.
REQ-023 After iRST deasserts, the first rising edge with iSTART=1 SHALL be accepted.

Structure
REQ-024 Shared package bin2bcd_pkg SHALL hold the FSM state type (IDLE/SHIFT/DONE) and the BCD nibble width constant (4).
REQ-025 Sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 if >=5) SHALL be instantiated DIGITS times inside bin2bcd_seq.
REQ-026 The counter SHALL be sized $clog2(WIDTH+1) bits; no other arithmetic wider than 4 bits per digit.

Verification
REQ-027 iBIN=0, iSTART pulse -> oDONE 17 cycles later, oBCD=20'h00000, oBLANK=5'b11110.
REQ-028 iBIN=65535 -> oBCD=20'h65535, oBLANK=5'b00000, oBUSY high for exactly 17 cycles.
REQ-029 iBIN=1234 -> oBCD=20'h01234, oBLANK=5'b10000; then iBIN=7 with iSTART in the cycle after oDONE -> oBCD=20'h00007, oBLANK=5'b11110.
REQ-030 iBIN=500 started, then iSTART with iBIN=999 at cycle 5 of SHIFT -> second request ignored, oBCD=20'h00500, one oDONE pulse only.
REQ-031 iBIN=4321 started, iRST pulsed at cycle 8 of SHIFT -> outputs return to reset values immediately, no oDONE; next conversion of 42 -> oBCD=20'h00042.
REQ-032 Randomized sweep of 1000 values vs. a reference model -> every oBCD matches, every nibble <= 9.
